// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard hazard stall, writeback bypass,
// and a registered valid/ready output slot toward execute.
module operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_we,
    output logic [ADDR_W-1:0] reg_read_addr_1,
    output logic [ADDR_W-1:0] reg_read_addr_2,
    input  logic [DATA_W-1:0] reg_read_data_1,
    input  logic [DATA_W-1:0] reg_read_data_2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_we,
    output logic [15:0]       stall_cnt
);
    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic              byp_1;
    logic              byp_2;
    logic              byp_d;
    logic              hz_1;
    logic              hz_2;
    logic              hz_d;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign reg_read_addr_1 = in_rs1;
    assign reg_read_addr_2 = in_rs2;

    // A write landing this very cycle resolves the hazard it would cause.
    assign byp_1 = wb_en && (wb_dest == in_rs1);
    assign byp_2 = wb_en && (wb_dest == in_rs2);
    assign byp_d = wb_en && (wb_dest == in_rd);

    assign hz_1 = pend[in_rs1] && !byp_1;
    assign hz_2 = pend[in_rs2] && !byp_2;
    assign hz_d = in_rd_we && pend[in_rd] && !byp_d;

    assign hazard   = in_valid && (hz_1 || hz_2 || hz_d);
    assign in_ready = !rst && (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    assign opnd_a = byp_1 ? wb_data : reg_read_data_1;
    assign opnd_b = byp_2 ? wb_data : reg_read_data_2;

    // Clear before set so a same-cycle reissue keeps the bit pending.
    always_comb begin
        pend_nxt = pend;
        if (wb_en) begin
            pend_nxt[wb_dest] = 1'b0;
        end
        if (accept && in_rd_we) begin
            pend_nxt[in_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            out_valid <= 1'b0;
            out_op    <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_rd    <= '0;
            out_rd_we <= 1'b0;
            stall_cnt <= '0;
        end else begin
            pend <= pend_nxt;
            if (accept) begin
                out_valid <= 1'b1;
                out_op    <= in_op;
                out_a     <= opnd_a;
                out_b     <= opnd_b;
                out_rd    <= in_rd;
                out_rd_we <= in_rd_we;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (hazard && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized and directed bench for operand_fetch with a queue-based
// scoreboard and a separate output monitor.
module tb_operand_fetch;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int NR = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [AW-1:0] in_rd;
    logic          in_rd_we;
    logic [AW-1:0] reg_read_addr_1;
    logic [AW-1:0] reg_read_addr_2;
    logic [DW-1:0] reg_read_data_1;
    logic [DW-1:0] reg_read_data_2;
    logic          wb_en;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_op;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [AW-1:0] out_rd;
    logic          out_rd_we;
    logic [15:0]   stall_cnt;

    always #5 clk = ~clk;

    operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_rd_we(in_rd_we),
        .reg_read_addr_1(reg_read_addr_1),
        .reg_read_addr_2(reg_read_addr_2),
        .reg_read_data_1(reg_read_data_1),
        .reg_read_data_2(reg_read_data_2),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_rd_we(out_rd_we),
        .stall_cnt(stall_cnt)
    );

    // Register file the stage reads from; written by the writeback port.
    logic [DW-1:0] rf [NR];
    assign reg_read_data_1 = rf[reg_read_addr_1];
    assign reg_read_data_2 = rf[reg_read_addr_2];
    always @(posedge clk) if (wb_en) rf[wb_dest] <= wb_data;

    typedef struct packed {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic          we;
    } exp_t;

    exp_t q[$];
    bit   pend_m [NR];
    bit   ov_m;
    int   stall_m;
    int   nvec = 0;
    int   nerr = 0;
    int   want_stall = -1;
    bit   want_zero = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic bit src_hz(input bit [2:0] r, input bit wbe,
                                  input bit [2:0] wbd);
        return pend_m[r] && !(wbe && wbd == r);
    endfunction

    task automatic step(input bit v, input bit [3:0] op,
                        input bit [2:0] s1, input bit [2:0] s2,
                        input bit [2:0] d, input bit we,
                        input bit wbe, input bit [2:0] wbd,
                        input bit [15:0] wbdat, input bit ordy,
                        input bit r);
        bit   hz;
        bit   rdy;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_op = op;
        in_rs1 = s1; in_rs2 = s2; in_rd = d; in_rd_we = we;
        wb_en = wbe; wb_dest = wbd; wb_data = wbdat;
        out_ready = ordy;
        #1;
        hz = v && (src_hz(s1, wbe, wbd) || src_hz(s2, wbe, wbd)
                   || (we && src_hz(d, wbe, wbd)));
        rdy = !r && (!ov_m || ordy) && !hz;
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, ov_m);
        chk("stall_cnt", stall_cnt, stall_m);
        chk("rd_addr", {reg_read_addr_1, reg_read_addr_2}, {s1, s2});
        if (want_stall >= 0) chk("stall_exact", stall_cnt, want_stall);
        want_stall = -1;
        if (want_zero) begin
            chk("rst_out", {out_valid, out_op, out_a, out_b,
                            out_rd, out_rd_we, stall_cnt}, 0);
        end
        want_zero = 0;
        if (r) begin
            foreach (pend_m[i]) pend_m[i] = 0;
            ov_m = 0;
            stall_m = 0;
            q.delete();
        end else begin
            if (wbe) pend_m[wbd] = 0;
            if (v && rdy) begin
                e.op = op;
                e.a  = (wbe && wbd == s1) ? wbdat : rf[s1];
                e.b  = (wbe && wbd == s2) ? wbdat : rf[s2];
                e.rd = d;
                e.we = we;
                q.push_back(e);
                ov_m = 1;
                if (we) pend_m[d] = 1;
            end else if (ordy) begin
                ov_m = 0;
            end
            if (hz && stall_m != 16'hFFFF) stall_m++;
        end
    endtask

    // Output monitor: checks each transfer and stability under backpressure.
    exp_t prev;
    bit   hold = 0;
    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
        end else begin
            if (hold) begin
                chk("hold_stable",
                    {out_op, out_a, out_b, out_rd, out_rd_we}, prev);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_out: got op %0h a %0h, want none",
                             out_op, out_a);
                end else begin
                    chk("out_data", {out_op, out_a, out_b, out_rd, out_rd_we},
                        q.pop_front());
                end
            end
            hold = out_valid && !out_ready;
            prev = {out_op, out_a, out_b, out_rd, out_rd_we};
        end
    end

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        want_zero = 1;
    endtask

    initial begin
        bit [2:0] pl[$];
        bit       wbe;
        bit [2:0] wbd;
        rst = 1; in_valid = 0; in_op = 0; in_rs1 = 0; in_rs2 = 0;
        in_rd = 0; in_rd_we = 0; wb_en = 0; wb_dest = 0; wb_data = 0;
        out_ready = 0;
        for (int i = 0; i < NR; i++) rf[i] = DW'($urandom);
        rf[1] = 16'h0011;
        rf[2] = 16'h0022;
        ov_m = 0; stall_m = 0;
        foreach (pend_m[i]) pend_m[i] = 0;
        do_reset();
        do_reset();

        // Basic issue, then RAW stall resolved by a same-cycle writeback.
        step(1, 3, 1, 2, 4, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 4, 0, 0, 0, 0, 0, 0, 1, 0);
        want_stall = 3;
        step(1, 0, 4, 0, 0, 0, 1, 4, 16'hBEEF, 1, 0);
        step(1, 1, 4, 4, 0, 0, 0, 0, 0, 1, 0);

        // WAW: stalled without writeback, accepted alongside it.
        step(1, 2, 0, 0, 5, 1, 0, 0, 0, 1, 0);
        step(1, 2, 0, 0, 5, 1, 0, 0, 0, 1, 0);
        step(1, 2, 0, 0, 5, 1, 1, 5, 16'h5555, 1, 0);
        step(1, 2, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 5, 16'h1234, 1, 0);

        // Backpressure for four cycles, then release.
        step(1, 7, 1, 2, 3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 9, 2, 1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 9, 2, 1, 0, 1, 0, 0, 0, 1, 0);
        idle(1);
        idle(1);

        // Reset mid-flight drops the output and the pending write.
        step(1, 4, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        do_reset();
        step(1, 5, 6, 6, 6, 1, 0, 0, 0, 1, 0);
        idle(1);

        for (int n = 0; n < 3000; n++) begin
            pl.delete();
            foreach (pend_m[i]) if (pend_m[i]) pl.push_back(3'(i));
            wbe = ($urandom_range(0, 1) == 1);
            wbd = 3'($urandom);
            if (pl.size() > 0 && $urandom_range(0, 3) != 0)
                wbd = pl[$urandom_range(0, pl.size() - 1)];
            step($urandom_range(0, 4) != 0, 4'($urandom),
                 3'($urandom), 3'($urandom), 3'($urandom),
                 1'($urandom), wbe, wbd, 16'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
        end
        idle(1);
        idle(1);
        idle(1);
        chk("drain", q.size(), 0);

        // Saturating stall counter.
        do_reset();
        step(1, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 65534; i++)
            step(1, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0);
        want_stall = 16'hFFFE;
        for (int i = 0; i < 3; i++)
            step(1, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0);
        want_stall = 16'hFFFF;
        idle(1);
        idle(1);
        chk("final_drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 16, which sets the operand and writeback data width.
REQ-002 SHALL have parameter ADDR_W, default 3, which sets the register index width (2**ADDR_W = 8 registers).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1): the upstream decode handshake.
REQ-006 SHALL have inputs in_op (4), in_rs1 (ADDR_W), in_rs2 (ADDR_W), in_rd (ADDR_W) and in_rd_we (1): the decoded instruction fields.
REQ-007 SHALL have outputs reg_read_addr_1 and reg_read_addr_2 (ADDR_W), and inputs reg_read_data_1 and reg_read_data_2 (DATA_W), connected to the register file's combinational read ports.
REQ-008 SHALL have inputs wb_en (1), wb_dest (ADDR_W) and wb_data (DATA_W), tapped from the same signals that drive the register file write port.
REQ-009 SHALL have outputs out_valid (1) and input out_ready (1): the downstream execute handshake.
REQ-010 SHALL have outputs out_op (4), out_a (DATA_W), out_b (DATA_W), out_rd (ADDR_W) and out_rd_we (1).
REQ-011 SHALL have output stall_cnt, 16 bits, counting hazard-stall cycles.

Function
REQ-012 SHALL drive reg_read_addr_1 = in_rs1 and reg_read_addr_2 = in_rs2 combinationally at all times.
REQ-013 SHALL keep a scoreboard, pend[7:0], where bit r = 1 means a write to r has been issued but not yet written back.
REQ-014 SHALL treat a source as hazardous when (pend[rs] = 1) and not (wb_en = 1 and wb_dest = rs); hazard = in_valid and (rs1 hazardous, or rs2 hazardous, or (in_rd_we = 1 and in_rd hazardous)).
REQ-015 SHALL compute in_ready = (!out_valid or out_ready) and !hazard; accept = in_valid and in_ready.
REQ-016 SHALL, on accept, register out_op, out_rd and out_rd_we from the inputs, set out_valid = 1, and present them one cycle after acceptance.
REQ-017 SHALL bypass on accept: out_a = wb_data if wb_en = 1 and wb_dest = in_rs1, else out_a = reg_read_data_1; out_b follows the same rule with in_rs2 and reg_read_data_2.
REQ-018 SHALL clear out_valid when out_ready = 1 and there is no accept; while out_valid = 1 and out_ready = 0, all out_* outputs SHALL hold stable.
REQ-019 SHALL, each cycle, clear pend[wb_dest] when wb_en = 1, then set pend[in_rd] when accept = 1 and in_rd_we = 1; if both act on the same bit in the same cycle, the set wins and the bit stays 1.
REQ-020 SHALL ignore wb_en to a register whose pend bit is 0, apart from the bypass in REQ-017.
REQ-021 SHALL increment stall_cnt by 1 in each cycle where in_valid = 1 and hazard = 1, saturating at 16'hFFFF.
REQ-022 SHALL treat register 0 like any other register; it is not hardwired to zero.

Reset
REQ-023 SHALL, when rst = 1 at a clock edge, set out_valid = 0, pend = 0 and stall_cnt = 0, and zero all out_* data and index outputs; reset overrides any accept or writeback in that cycle.
REQ-024 SHALL hold in_ready = 0 during a cycle in which rst = 1.
REQ-025 SHALL, on reset mid-operation, discard any in-flight output without presenting it, and forget all pending writes.

Verification
REQ-026 SHALL pass this case: rf r1 = 16'h0011, r2 = 16'h0022; issue op = 3, rs1 = 1, rs2 = 2, rd = 4, we = 1 -> next cycle out_valid = 1, out_a = 0011, out_b = 0022, out_rd = 4, pend[4] = 1.
REQ-027 SHALL pass this case: with pend[4] = 1, issue rs1 = 4 with no writeback for 3 cycles -> in_ready = 0 for 3 cycles and stall_cnt = 3; then wb_en = 1, wb_dest = 4, wb_data = 16'hBEEF -> accepted that cycle, out_a = BEEF, pend[4] = 0.
REQ-028 SHALL pass this case: with pend[5] = 1, issue rd = 5, we = 1 in the same cycle as wb_en = 1, wb_dest = 5 -> accepted and pend[5] remains 1; without that writeback, the issue is stalled (WAW).
REQ-029 SHALL pass this case: with out_valid = 1, hold out_ready = 0 for 4 cycles while in_valid = 1 -> in_ready = 0, out_* stable; with out_ready = 1 -> next instruction presented the following cycle.
REQ-030 SHALL pass this case: accept an instruction with rd = 6, we = 1, then assert rst = 1 for 1 cycle -> out_valid = 0, pend = 0, stall_cnt = 0; afterwards an issue with rs1 = 6 is accepted without stalling.
REQ-031 SHALL pass this case: preload stall_cnt = FFFE via a sustained hazard, then run 3 more stall cycles -> stall_cnt = FFFF and no wrap to 0.
